adma_fifo_ctrl: RTL and testbench

//  Sequences the ADMA data FIFO for one multi-block transfer. Gates the source

---
 rtl/adma_fifo_ctrl_pkg.sv | 16 +
 rtl/adma_fifo_ctrl_blk_word_counter.sv | 53 +++++
 rtl/adma_fifo_ctrl.sv | 156 +++++++++++++++
 tb/tb_adma_fifo_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adma_fifo_ctrl_pkg.sv
// Shared types and constants for the ADMA FIFO controller.
package adma_fifo_ctrl_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int WORD_CNT_W_DEF = 12;
  localparam int BLK_CNT_W_DEF  = 16;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adma_fifo_ctrl_blk_word_counter.sv
// Words-per-block / blocks-per-transfer counter. One instance tracks the
// FIFO write side, another the read side. The word count wraps to 0 after the
// last word of a block, and each wrap retires one block; blocks_left never
// goes below zero.
module adma_fifo_ctrl_blk_word_counter #(
  parameter int WORD_CNT_W = 12,
  parameter int BLK_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_inc,
  input  logic [WORD_CNT_W-1:0] i_blk_words,
  input  logic [BLK_CNT_W-1:0]  i_blk_count,
  output logic [BLK_CNT_W-1:0]  o_blocks_left,
  output logic                  o_wrap
);

  localparam logic [WORD_CNT_W-1:0] WORD_ONE = WORD_CNT_W'(1);
  localparam logic [BLK_CNT_W-1:0]  BLK_ONE  = BLK_CNT_W'(1);

  logic [WORD_CNT_W-1:0] r_word;
  logic [WORD_CNT_W-1:0] r_blk_words;
  logic [BLK_CNT_W-1:0]  r_blocks_left;
  logic                  w_active;

  assign w_active      = i_inc & (r_blocks_left != '0);
  assign o_wrap        = w_active & (r_word == (r_blk_words - WORD_ONE));
  assign o_blocks_left = r_blocks_left;

  // Word/block counting: load on start, advance on each accepted word.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its peers, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word        <= '0;
      r_blk_words   <= '0;
      r_blocks_left <= '0;
    end else if (i_load) begin
      r_word        <= '0;
      r_blk_words   <= i_blk_words;
      r_blocks_left <= i_blk_count;
    end else if (w_active) begin
      if (o_wrap) begin
        r_word        <= '0;
        r_blocks_left <= r_blocks_left - BLK_ONE;
      end else begin
        r_word <= r_word + WORD_ONE;
      end
    end
  end

endmodule

// File: rtl/adma_fifo_ctrl.sv
// ADMA data FIFO sequencer for one multi-block transfer: gates source writes
// and sink reads with valid/ready, counts words/blocks on both FIFO ports,
// reports block/transfer completion and drains the FIFO on abort.
module adma_fifo_ctrl
  import adma_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WORD_CNT_W = WORD_CNT_W_DEF,
  parameter int BLK_CNT_W  = BLK_CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_CNT_W-1:0] blk_words,
  input  logic [BLK_CNT_W-1:0]  blk_count,
  input  logic                  src_valid,
  input  logic [DATA_W-1:0]     src_data,
  output logic                  src_ready,
  output logic                  dst_valid,
  output logic [DATA_W-1:0]     dst_data,
  input  logic                  dst_ready,
  output logic [DATA_W-1:0]     fifo_data_in,
  input  logic [DATA_W-1:0]     fifo_data_out,
  output logic                  fifo_write,
  output logic                  fifo_read,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic                  busy,
  output logic                  blk_done,
  output logic                  xfer_done,
  output logic                  xfer_err,
  output logic [BLK_CNT_W-1:0]  blocks_left
);

  localparam logic [BLK_CNT_W-1:0] BLK_ONE = BLK_CNT_W'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_blk_done;
  logic                  r_xfer_err;
  logic                  w_set_err;
  logic                  w_zero_size;
  logic                  w_start_ok;
  logic                  w_run;
  logic                  w_rd_pop;
  logic                  w_last_pop;
  logic [BLK_CNT_W-1:0]  w_load_count;
  logic [BLK_CNT_W-1:0]  w_wr_blocks_left;
  logic [BLK_CNT_W-1:0]  w_rd_blocks_left;
  logic                  w_wr_wrap;
  logic                  w_rd_wrap;

  assign w_zero_size  = (blk_words == '0) | (blk_count == '0);
  assign w_start_ok   = start & (r_state == ST_IDLE);
  // A zero-size request loads an empty transfer so blocks_left reads 0.
  assign w_load_count = w_zero_size ? '0 : blk_count;
  assign w_run        = (r_state == ST_RUN);

  // Write side: source -> FIFO, runs ahead of the read side across blocks.
  assign src_ready    = w_run & ~fifo_full & (w_wr_blocks_left != '0);
  assign fifo_write   = src_valid & src_ready;
  assign fifo_data_in = src_data;

  // Read side: FIFO -> sink; in DRAIN the FIFO is emptied without a sink.
  assign dst_valid    = w_run & ~fifo_empty;
  assign dst_data     = fifo_data_out;
  assign w_rd_pop     = dst_valid & dst_ready;
  assign fifo_read    = w_rd_pop | ((r_state == ST_DRAIN) & ~fifo_empty);
  assign w_last_pop   = w_rd_wrap & (w_rd_blocks_left == BLK_ONE);

  assign busy         = (r_state != ST_IDLE);
  assign xfer_done    = (r_state == ST_DONE);
  assign blk_done     = r_blk_done;
  assign xfer_err     = r_xfer_err;
  assign blocks_left  = w_rd_blocks_left;

  adma_fifo_ctrl_blk_word_counter #(
    .WORD_CNT_W (WORD_CNT_W),
    .BLK_CNT_W  (BLK_CNT_W)
  ) u_wr_cnt (
    .clk           (CLK),
    .rst_n         (RESET_N),
    .i_load        (w_start_ok),
    .i_inc         (fifo_write),
    .i_blk_words   (blk_words),
    .i_blk_count   (w_load_count),
    .o_blocks_left (w_wr_blocks_left),
    .o_wrap        (w_wr_wrap)
  );

  adma_fifo_ctrl_blk_word_counter #(
    .WORD_CNT_W (WORD_CNT_W),
    .BLK_CNT_W  (BLK_CNT_W)
  ) u_rd_cnt (
    .clk           (CLK),
    .rst_n         (RESET_N),
    .i_load        (w_start_ok),
    .i_inc         (w_rd_pop),
    .i_blk_words   (blk_words),
    .i_blk_count   (w_load_count),
    .o_blocks_left (w_rd_blocks_left),
    .o_wrap        (w_rd_wrap)
  );

  // Next-state logic; completion takes priority over a same-cycle abort.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_set_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_zero_size ? ST_DONE : ST_RUN;
          w_set_err   = w_zero_size;
        end
      end
      ST_RUN: begin
        if (w_last_pop)  w_state_nxt = ST_DONE;
        else if (abort)  w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          w_state_nxt = ST_DONE;
          w_set_err   = 1'b1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Registered block-done pulse and sticky error (cleared by an accepted start).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_blk_done <= 1'b0;
      r_xfer_err <= 1'b0;
    end else begin
      r_blk_done <= w_rd_wrap;
      if (w_set_err)       r_xfer_err <= 1'b1;
      else if (w_start_ok) r_xfer_err <= 1'b0;
    end
  end

  // The write side may run ahead of the read side, never behind it.
  a_wr_ahead : assert property (@(posedge CLK) disable iff (!RESET_N)
    w_wr_wrap |-> (w_wr_blocks_left <= w_rd_blocks_left));

endmodule

// File: tb/tb_adma_fifo_ctrl.sv
// Bench for adma_fifo_ctrl: a depth-8 show-ahead FIFO model, a scoreboard of
// written words compared at each sink handshake, a table of transfers and
// hand-written abort / reset / stall / restart sequences.
module tb_adma_fifo_ctrl;

  localparam int DEPTH = 8;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] blk_words = '0;
  logic [15:0] blk_count = '0;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = '0;
  logic        dst_ready = 1'b0;
  logic [31:0] fifo_data_out = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        src_ready, dst_valid, fifo_write, fifo_read;
  logic        busy, blk_done, xfer_done, xfer_err;
  logic [31:0] dst_data, fifo_data_in;
  logic [15:0] blocks_left;

  adma_fifo_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .abort(abort),
    .blk_words(blk_words), .blk_count(blk_count),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
    .fifo_data_in(fifo_data_in), .fifo_data_out(fifo_data_out),
    .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .busy(busy), .blk_done(blk_done), .xfer_done(xfer_done),
    .xfer_err(xfer_err), .blocks_left(blocks_left)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state (sampled at negedge) and stimulus controls.
  int          n_writes = 0, n_reads = 0, n_drain = 0, n_done = 0, n_busy = 0, n_viol = 0;
  int          sent = 0, total = 0, src_pat = 0, dst_pat = 0, cyc = 0;
  int          read_limit = 1 << 30;
  bit          dst_stop = 1'b0, drain_watch = 1'b0, err_at_done = 1'b0, flush = 1'b0;
  bit          m_wr = 1'b0, m_rd = 1'b0;
  logic [31:0] m_wd = '0;
  logic [31:0] base = '0;
  logic [31:0] sb[$];
  logic [31:0] fq[$];
  int          blk_at[$];

  // Show-ahead FIFO model, updated from strobes latched at the previous negedge.
  always @(posedge CLK) begin
    if (flush) fq.delete();
    else begin
      if (m_rd && fq.size() > 0) void'(fq.pop_front());
      if (m_wr) fq.push_back(m_wd);
    end
    fifo_empty    <= (fq.size() == 0);
    fifo_full     <= (fq.size() >= DEPTH);
    fifo_data_out <= (fq.size() > 0) ? fq[0] : 32'h0;
  end

  // Monitor: scoreboard, counters and protocol violations.
  always @(negedge CLK) begin
    logic [31:0] exp_w;
    m_wr = fifo_write;
    m_rd = fifo_read;
    m_wd = fifo_data_in;
    if (blk_done) blk_at.push_back(n_reads);
    if (fifo_write) begin
      sb.push_back(src_data);
      n_writes++;
      sent++;
      if (fifo_full || !src_valid) n_viol++;
    end
    if (fifo_read) begin
      if (fifo_empty) n_viol++;
      if (dst_valid) begin
        if (!dst_ready) n_viol++;
        n_reads++;
        if (sb.size() == 0) check("sb_underflow", 64'(n_reads), 64'(0));
        else begin
          exp_w = sb.pop_front();
          check("dst_data", dst_data, exp_w);
        end
      end else n_drain++;
    end
    if (dst_valid && dst_ready && !fifo_read) n_viol++;
    if (drain_watch && (src_ready || dst_valid)) n_viol++;
    if (xfer_done) begin
      n_done++;
      err_at_done = xfer_err;
    end
    if (busy) n_busy++;
  end

  function automatic bit pat_ok(input int pat, input int c);
    return (pat < 2) ? 1'b1 : ((c % pat) != 0);
  endfunction

  task automatic step(input bit do_start, input bit do_abort);
    @(posedge CLK);
    #1;
    cyc++;
    start     = do_start;
    abort     = do_abort;
    src_valid = (sent < total) && pat_ok(src_pat, cyc);
    src_data  = base + 32'(sent);
    dst_ready = !dst_stop && (n_reads < read_limit) && pat_ok(dst_pat, cyc);
  endtask

  task automatic clear_counts();
    n_writes = 0; n_reads = 0; n_drain = 0; n_done = 0; n_busy = 0; n_viol = 0;
    sent = 0; drain_watch = 1'b0; err_at_done = 1'b0;
    sb.delete();
    blk_at.delete();
  endtask

  task automatic start_xfer(input int bw, input int bc, input int sp, input int dp, input int tot);
    clear_counts();
    blk_words  = 12'(bw);
    blk_count  = 16'(bc);
    src_pat    = sp;
    dst_pat    = dp;
    total      = tot;
    read_limit = 1 << 30;
    dst_stop   = 1'b0;
    base       = $urandom;
    step(1'b1, 1'b0);
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      step(1'b0, 1'b0);
      k++;
    end
    check({name, "_done_seen"}, 64'(n_done != 0), 64'(1));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic check_xfer(input string name, input int bw, input int bc, input bit exp_err);
    int words = exp_err ? 0 : bw * bc;
    int nblk  = exp_err ? 0 : bc;
    check({name, "_writes"},   64'(n_writes), 64'(words));
    check({name, "_reads"},    64'(n_reads), 64'(words));
    check({name, "_drain"},    64'(n_drain), 64'(0));
    check({name, "_done_cnt"}, 64'(n_done), 64'(1));
    check({name, "_err_done"}, 64'(err_at_done), 64'(exp_err));
    check({name, "_err_held"}, 64'(xfer_err), 64'(exp_err));
    check({name, "_blk_cnt"},  64'(blk_at.size()), 64'(nblk));
    for (int i = 0; i < blk_at.size() && i < nblk; i++)
      check({name, "_blk_pos"}, 64'(blk_at[i]), 64'(bw * (i + 1)));
    check({name, "_blocks_left"}, 64'(blocks_left), 64'(0));
    check({name, "_viol"},     64'(n_viol), 64'(0));
    check({name, "_sb_left"},  64'(sb.size()), 64'(0));
    check({name, "_busy_end"}, 64'(busy), 64'(0));
    if (exp_err) check({name, "_busy_cycles"}, 64'(n_busy), 64'(1));
  endtask

  function automatic logic [63:0] out_vec();
    return {36'h0, src_ready, dst_valid, fifo_write, fifo_read, busy,
            blk_done, xfer_done, xfer_err, blocks_left, 4'h0};
  endfunction

  typedef struct {
    int bw;
    int bc;
    int sp;
    int dp;
    bit err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k;
    vecs[0] = '{bw: 4, bc: 2, sp: 0, dp: 0, err: 1'b0};
    vecs[1] = '{bw: 3, bc: 3, sp: 3, dp: 2, err: 1'b0};
    vecs[2] = '{bw: 1, bc: 5, sp: 0, dp: 3, err: 1'b0};
    vecs[3] = '{bw: 4, bc: 0, sp: 0, dp: 0, err: 1'b1};
    vecs[4] = '{bw: 0, bc: 3, sp: 0, dp: 0, err: 1'b1};
    vecs[5] = '{bw: 5, bc: 2, sp: 2, dp: 0, err: 1'b0};

    // Reset values, during and just after reset.
    repeat (3) @(posedge CLK);
    #1 check("reset_outputs", out_vec(), 64'h0);
    @(negedge CLK) RESET_N = 1'b1;
    step(1'b0, 1'b0);
    check("idle_outputs", out_vec(), 64'h0);

    // Table-driven transfers.
    foreach (vecs[i]) begin
      start_xfer(vecs[i].bw, vecs[i].bc, vecs[i].sp, vecs[i].dp,
                 vecs[i].err ? 0 : vecs[i].bw * vecs[i].bc);
      wait_done(400, $sformatf("vec%0d", i));
      check_xfer($sformatf("vec%0d", i), vecs[i].bw, vecs[i].bc, vecs[i].err);
    end

    // Sink stalled while 16 words are offered: writes stop at full.
    start_xfer(8, 2, 0, 0, 16);
    dst_stop = 1'b1;
    repeat (20) step(1'b0, 1'b0);
    check("stall_writes", 64'(n_writes), 64'(DEPTH));
    check("stall_src_ready", 64'(src_ready), 64'(0));
    check("stall_full", 64'(fifo_full), 64'(1));
    dst_stop = 1'b0;
    wait_done(400, "stall");
    check_xfer("stall", 8, 2, 1'b0);

    // Abort after 5 written and 2 read: DRAIN discards the remaining 3.
    start_xfer(8, 1, 0, 0, 5);
    dst_stop = 1'b1;
    k = 0;
    while (n_writes < 5 && k < 50) begin step(1'b0, 1'b0); k++; end
    check("abort_writes", 64'(n_writes), 64'(5));
    dst_stop   = 1'b0;
    read_limit = 2;
    k = 0;
    while (n_reads < 2 && k < 50) begin step(1'b0, 1'b0); k++; end
    check("abort_reads", 64'(n_reads), 64'(2));
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    drain_watch = 1'b1;
    wait_done(50, "abort");
    check("abort_drain", 64'(n_drain), 64'(3));
    check("abort_err_done", 64'(err_at_done), 64'(1));
    check("abort_err_held", 64'(xfer_err), 64'(1));
    check("abort_empty", 64'(fifo_empty), 64'(1));
    check("abort_viol", 64'(n_viol), 64'(0));
    check("abort_blk_done", 64'(blk_at.size()), 64'(0));
    check("abort_blocks_left", 64'(blocks_left), 64'(1));
    check("abort_writes_end", 64'(n_writes), 64'(5));
    drain_watch = 1'b0;

    // Reset mid-transfer clears outputs without a clock edge.
    start_xfer(4, 2, 0, 0, 8);
    repeat (4) step(1'b0, 1'b0);
    check("busy_before_reset", 64'(busy), 64'(1));
    #1 RESET_N = 1'b0;
    #1 check("async_reset_outputs", out_vec(), 64'h0);
    flush = 1'b1;
    step(1'b0, 1'b0);
    flush = 1'b0;
    clear_counts();
    total = 0;
    @(negedge CLK) RESET_N = 1'b1;
    start_xfer(4, 1, 0, 0, 4);
    wait_done(200, "post_reset");
    check_xfer("post_reset", 4, 1, 1'b0);

    // A second start during RUN changes nothing.
    start_xfer(4, 3, 0, 0, 12);
    dst_stop = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    check("restart_before", 64'(blocks_left), 64'(3));
    blk_words = 12'd2;
    blk_count = 16'd9;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("restart_blocks_left", 64'(blocks_left), 64'(3));
    check("restart_busy", 64'(busy), 64'(1));
    dst_stop = 1'b0;
    wait_done(400, "restart");
    check_xfer("restart", 4, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
